// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller for the in-order pipeline: shadows in-flight destinations and decides stall/bubble/forward at decode.
// Optional feature macro HAZ_FWD_EN: forwarding plus load-use stall; undefined waits for write-back instead.
module pipe_hazard_unit #(
    parameter int  RF_ADDRESS = 5,
    parameter int  DEPTH      = 3,
    parameter int  LOAD_STAGE = 2,
    parameter int  CNT_W      = 32,
    localparam int SEL_W      = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  id_valid,
    input  logic [RF_ADDRESS-1:0] id_rs1,
    input  logic [RF_ADDRESS-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [RF_ADDRESS-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    output logic                  stall_o,
    output logic [SEL_W-1:0]      ex_fwd_a,
    output logic [SEL_W-1:0]      ex_fwd_b,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    // The write-back slot is never consulted (regfile writes through), so only EX..DEPTH-1 are kept.
    logic [DEPTH-1:1]      sh_vld;
    logic [DEPTH-1:1]      sh_rw;
    logic [RF_ADDRESS-1:0] sh_rd [1:DEPTH-1];

    logic [DEPTH-1:1] match_a;
    logic [DEPTH-1:1] match_b;
    logic             hazard;
    logic             advance;

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int s = 1; s < DEPTH; s++) begin
            match_a[s] = id_valid & id_rs1_used & (id_rs1 != '0) &
                         sh_vld[s] & sh_rw[s] & (sh_rd[s] == id_rs1);
            match_b[s] = id_valid & id_rs2_used & (id_rs2 != '0) &
                         sh_vld[s] & sh_rw[s] & (sh_rd[s] == id_rs2);
        end
    end

    // A taken branch overrides any stall so the PC can take the target.
    assign stall_o = hazard & ~flush;
    assign advance = id_valid & ~stall_o & ~flush;

`ifdef HAZ_FWD_EN
    logic [DEPTH-1:1] sh_ld;
    logic [DEPTH-1:1] early;

    // Loads whose data does not yet exist when the consumer would reach EX.
    always_comb begin
        early = '0;
        for (int s = 1; s < DEPTH; s++)
            early[s] = (s < LOAD_STAGE);
    end

    assign hazard = |((match_a | match_b) & sh_ld & early);

    function automatic logic [SEL_W-1:0] youngest_sel(input logic [DEPTH-1:1] m);
        logic [SEL_W-1:0] sel;
        sel = '0;
        for (int s = DEPTH - 1; s >= 1; s--)
            if (m[s])
                sel = SEL_W'(s + 1);
        return sel;
    endfunction

    // The producer will have advanced one stage by the time the consumer is in EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end else if (advance) begin
            ex_fwd_a <= youngest_sel(match_a);
            ex_fwd_b <= youngest_sel(match_b);
        end else begin
            ex_fwd_a <= '0;
            ex_fwd_b <= '0;
        end
    end
`else
    logic           unused_memread;
    localparam int  UNUSED_LOAD_STAGE = LOAD_STAGE;

    assign unused_memread = id_memread;
    assign hazard         = |(match_a | match_b);
    assign ex_fwd_a       = '0;
    assign ex_fwd_b       = '0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_vld <= '0;
            sh_rw  <= '0;
            for (int s = 1; s < DEPTH; s++)
                sh_rd[s] <= '0;
`ifdef HAZ_FWD_EN
            sh_ld  <= '0;
`endif
        end else begin
            sh_vld[1] <= advance;
            sh_rw[1]  <= id_regwrite;
            sh_rd[1]  <= id_rd;
`ifdef HAZ_FWD_EN
            sh_ld[1]  <= id_memread;
`endif
            for (int s = 2; s < DEPTH; s++) begin
                sh_vld[s] <= sh_vld[s-1];
                sh_rw[s]  <= sh_rw[s-1];
                sh_rd[s]  <= sh_rd[s-1];
`ifdef HAZ_FWD_EN
                sh_ld[s]  <= sh_ld[s-1];
`endif
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_o && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit (DEPTH=3, LOAD_STAGE=2); expectations follow HAZ_FWD_EN when defined.
module tb_pipe_hazard_unit;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_rs1_used;
    logic       id_rs2_used;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       flush;
    logic       stall_o;
    logic [1:0] ex_fwd_a;
    logic [1:0] ex_fwd_b;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    logic       unused_sat_stall;
    logic [1:0] unused_sat_fwd_a;
    logic [1:0] unused_sat_fwd_b;
    logic [1:0] sat_stall_cnt;
    logic [1:0] sat_flush_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_unit dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall_o(stall_o),
        .ex_fwd_a(ex_fwd_a), .ex_fwd_b(ex_fwd_b),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    // Narrow-counter copy on the same inputs to reach saturation quickly.
    pipe_hazard_unit #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .stall_o(unused_sat_stall),
        .ex_fwd_a(unused_sat_fwd_a), .ex_fwd_b(unused_sat_fwd_b),
        .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change just after the falling edge; checks follow 1 time unit later.
    task automatic apply_stimulus(input logic v, input logic [4:0] rs1, input logic u1,
                                  input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                  input logic rw, input logic ld, input logic fl);
        @(negedge clk);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs1_used = u1;
        id_rs2      = rs2;
        id_rs2_used = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = ld;
        flush       = fl;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_regwrite = 0; id_memread = 0; flush = 0;
        #3;
        check_output("reset_stall", {31'd0, stall_o}, 0);
        check_output("reset_fwd_a", {30'd0, ex_fwd_a}, 0);
        check_output("reset_fwd_b", {30'd0, ex_fwd_b}, 0);
        check_output("reset_stall_cnt", stall_cnt, 0);
        check_output("reset_flush_cnt", flush_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        $display("[TB] reset released");

`ifdef HAZ_FWD_EN
        // add x5,x1,x2 ; add x6,x5,x1 back-to-back
        apply_stimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        check_output("b2b_prod_stall", {31'd0, stall_o}, 0);
        apply_stimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        check_output("b2b_cons_stall", {31'd0, stall_o}, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("b2b_fwd_a", {30'd0, ex_fwd_a}, 2);
        check_output("b2b_fwd_b", {30'd0, ex_fwd_b}, 0);
        // add x5 ; nop ; sub x7,x2,x5
        apply_stimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        apply_stimulus(1, 5'd2, 1, 5'd5, 1, 5'd7, 1, 0, 0);
        check_output("gap_stall", {31'd0, stall_o}, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("gap_fwd_a", {30'd0, ex_fwd_a}, 0);
        check_output("gap_fwd_b", {30'd0, ex_fwd_b}, 3);
        // lw x5,0(x1) ; add x6,x1,x5
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        check_output("lu_load_stall", {31'd0, stall_o}, 0);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("lu_stall_1", {31'd0, stall_o}, 1);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("lu_stall_2", {31'd0, stall_o}, 0);
        check_output("lu_stall_cnt", stall_cnt, 1);
        check_output("lu_bubble_fwd_b", {30'd0, ex_fwd_b}, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("lu_fwd_b", {30'd0, ex_fwd_b}, 3);
        check_output("lu_fwd_a", {30'd0, ex_fwd_a}, 0);
        // addi x0,x1,1 ; add x6,x0,x0
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        apply_stimulus(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0);
        check_output("x0_stall", {31'd0, stall_o}, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("x0_fwd_a", {30'd0, ex_fwd_a}, 0);
        check_output("x0_fwd_b", {30'd0, ex_fwd_b}, 0);
        // addi x5 ; addi x5 ; add x6,x5,x5 picks the younger producer
        apply_stimulus(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0);
        apply_stimulus(1, 5'd0, 1, 5'd0, 0, 5'd5, 1, 0, 0);
        apply_stimulus(1, 5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("young_stall", {31'd0, stall_o}, 0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("young_fwd_a", {30'd0, ex_fwd_a}, 2);
        check_output("young_fwd_b", {30'd0, ex_fwd_b}, 2);
        // lw x5 ; add x6,x1,x5 with flush in the same cycle ; add x7,x6,x0
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 1);
        check_output("flush_stall", {31'd0, stall_o}, 0);
        apply_stimulus(1, 5'd6, 1, 5'd0, 1, 5'd7, 1, 0, 0);
        check_output("flush_stall_after", {31'd0, stall_o}, 0);
        check_output("flush_fwd_b", {30'd0, ex_fwd_b}, 0);
        check_output("flush_cnt", flush_cnt, 1);
        check_output("flush_stall_cnt", stall_cnt, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("flush_bubble_fwd_a", {30'd0, ex_fwd_a}, 0);
`else
        // add x5,x1,x2 ; add x6,x5,x1 waits for write-back
        apply_stimulus(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0);
        check_output("b2b_prod_stall", {31'd0, stall_o}, 0);
        apply_stimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        check_output("b2b_stall_1", {31'd0, stall_o}, 1);
        apply_stimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        check_output("b2b_stall_2", {31'd0, stall_o}, 1);
        check_output("b2b_stall_cnt_1", stall_cnt, 1);
        apply_stimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
        check_output("b2b_stall_3", {31'd0, stall_o}, 0);
        check_output("b2b_stall_cnt_2", stall_cnt, 2);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("b2b_fwd_a", {30'd0, ex_fwd_a}, 0);
        check_output("b2b_fwd_b", {30'd0, ex_fwd_b}, 0);
        // addi x0,x1,1 ; add x6,x0,x0
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
        apply_stimulus(1, 5'd0, 1, 5'd0, 1, 5'd6, 1, 0, 0);
        check_output("x0_stall", {31'd0, stall_o}, 0);
        // lw x5 ; add x6,x1,x5 also waits two cycles
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("ld_stall_1", {31'd0, stall_o}, 1);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("ld_stall_2", {31'd0, stall_o}, 1);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("ld_stall_3", {31'd0, stall_o}, 0);
        check_output("ld_stall_cnt", stall_cnt, 4);
        // lw x5 ; add x6,x1,x5 with flush ; add x7,x6,x0
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 1);
        check_output("flush_stall", {31'd0, stall_o}, 0);
        apply_stimulus(1, 5'd6, 1, 5'd0, 1, 5'd7, 1, 0, 0);
        check_output("flush_stall_after", {31'd0, stall_o}, 0);
        check_output("flush_cnt", flush_cnt, 1);
        check_output("flush_stall_cnt", stall_cnt, 4);
`endif

        // Four more flush cycles: wide counter reaches 5, the 2-bit copy holds at 3.
        for (int i = 0; i < 4; i++)
            apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check_output("flush_cnt_5", flush_cnt, 5);
        check_output("sat_flush_cnt", {30'd0, sat_flush_cnt}, 3);
`ifdef HAZ_FWD_EN
        check_output("sat_stall_cnt", {30'd0, sat_stall_cnt}, 1);
`else
        check_output("sat_stall_cnt", {30'd0, sat_stall_cnt}, 3);
`endif

        // Reset in the middle of a pending load-use hazard.
        apply_stimulus(1, 5'd1, 1, 5'd0, 0, 5'd5, 1, 1, 0);
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("pre_reset_stall", {31'd0, stall_o}, 1);
        reset_n = 1'b0;
        #1;
        check_output("mid_reset_stall", {31'd0, stall_o}, 0);
        check_output("mid_reset_fwd_a", {30'd0, ex_fwd_a}, 0);
        check_output("mid_reset_fwd_b", {30'd0, ex_fwd_b}, 0);
        check_output("mid_reset_stall_cnt", stall_cnt, 0);
        check_output("mid_reset_flush_cnt", flush_cnt, 0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_stimulus(1, 5'd1, 1, 5'd5, 1, 5'd6, 1, 0, 0);
        check_output("post_reset_stall", {31'd0, stall_o}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
